// File: rtl/paper_pkg.sv
// paper_pkg: shared defaults and types for the paper-count meter.
// The optional watchdog is enabled by defining PAPER_TIMEOUT_EN.
package paper_pkg;

  localparam int          DEF_CNT_W     = 28;
  localparam int          DEF_AVG_LOG2  = 2;
  localparam int          DEF_MAX_PAPER = 10;
  localparam logic [27:0] DEF_TIMEOUT   = 28'd18_000_000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_AVG   = 3'd3,
    ST_STORE = 3'd4,
    ST_SCAN  = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  typedef logic [7:0] paper_cnt_t;

endpackage

// File: rtl/paper_ref_table.sv
// paper_ref_table: calibrated reference counts, one per paper count.
// One synchronous write port, one combinational indexed read.
module paper_ref_table
  import paper_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int MAX_PAPER = DEF_MAX_PAPER
) (
  input  logic               clk_6M,
  input  logic               reset_n,
  input  logic               we,
  input  logic [3:0]         waddr,
  input  logic [CNT_W-1:0]   wdata,
  input  logic [3:0]         raddr,
  output logic [CNT_W-1:0]   rdata,
  output logic               rvalid,
  output logic [MAX_PAPER:0] ref_valid
);

  logic [CNT_W-1:0] tbl_q [MAX_PAPER+1];
  logic [CNT_W-1:0] tbl_d [MAX_PAPER+1];
  logic [MAX_PAPER:0] vld_q, vld_d;

  // Write port: a store overwrites the entry and marks it valid.
  always_comb begin
    tbl_d = tbl_q;
    vld_d = vld_q;
    if (we) begin
      tbl_d[waddr] = wdata;
      vld_d[waddr] = 1'b1;
    end
  end

  // Entry storage, wiped by reset.
  always_ff @(posedge clk_6M or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= MAX_PAPER; i++) begin
        tbl_q[i] <= '0;
      end
      vld_q <= '0;
    end else begin
      tbl_q <= tbl_d;
      vld_q <= vld_d;
    end
  end

  assign rdata     = tbl_q[raddr];
  assign rvalid    = vld_q[raddr];
  assign ref_valid = vld_q;

endmodule

// File: rtl/paper_meas_ctrl.sv
// paper_meas_ctrl: gate-window sequencer, averager and nearest-reference
// classifier. Define PAPER_TIMEOUT_EN to add the per-window watchdog.
module paper_meas_ctrl
  import paper_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int AVG_LOG2  = DEF_AVG_LOG2,
  parameter int MAX_PAPER = DEF_MAX_PAPER,
  parameter logic [27:0] TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk_6M,
  input  logic               reset_n,
  input  logic               run,
  input  logic               cal_req,
  input  logic [3:0]         cal_idx,
  output logic               meas_start,
  input  logic               meas_done,
  input  logic [CNT_W-1:0]   meas_count,
  output logic [7:0]         number,
  output logic               number_valid,
  output logic               busy,
  output logic [MAX_PAPER:0] ref_valid,
  output logic               err
);

  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam logic [3:0] MAX_IDX = 4'(MAX_PAPER);
  localparam logic [AVG_LOG2:0] K_NUM =
    (AVG_LOG2+1)'(1 << AVG_LOG2);

  state_t           state_q, state_d;
  logic             cal_q, cal_d;
  logic [3:0]       idx_q, idx_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [AVG_LOG2:0] k_q, k_d;
  logic [CNT_W-1:0] avg_q, avg_d;
  logic [3:0]       sidx_q, sidx_d;
  logic [3:0]       best_q, best_d;
  logic [CNT_W-1:0] bdiff_q, bdiff_d;
  logic             found_q, found_d;
  paper_cnt_t       number_q, number_d;
  logic             nvalid_q, nvalid_d;
  logic             err_q, err_d;
  logic             tbl_we;
  logic [CNT_W-1:0] rd_data;
  logic             rd_valid;
  logic [CNT_W-1:0] diff;
  logic             take;
`ifdef PAPER_TIMEOUT_EN
  logic [27:0]      wd_q, wd_d;
`endif

  paper_ref_table #(
    .CNT_W     (CNT_W),
    .MAX_PAPER (MAX_PAPER)
  ) u_tbl (
    .clk_6M    (clk_6M),
    .reset_n   (reset_n),
    .we        (tbl_we),
    .waddr     (idx_q),
    .wdata     (avg_q),
    .raddr     (sidx_q),
    .rdata     (rd_data),
    .rvalid    (rd_valid),
    .ref_valid (ref_valid)
  );

  always_comb begin
    diff = (avg_q >= rd_data) ? (avg_q - rd_data) : (rd_data - avg_q);
    take = rd_valid && (!found_q || (diff < bdiff_q));
  end

  always_comb begin
    state_d  = state_q;
    cal_d    = cal_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    k_d      = k_q;
    avg_d    = avg_q;
    sidx_d   = sidx_q;
    best_d   = best_q;
    bdiff_d  = bdiff_q;
    found_d  = found_q;
    number_d = number_q;
    nvalid_d = 1'b0;
    err_d    = err_q;
    tbl_we   = 1'b0;
`ifdef PAPER_TIMEOUT_EN
    wd_d     = wd_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (cal_req) begin
          if (cal_idx > MAX_IDX) begin
            err_d = 1'b1;
          end else begin
            cal_d   = 1'b1;
            idx_d   = cal_idx;
            acc_d   = '0;
            k_d     = '0;
            err_d   = 1'b0;
            state_d = ST_START;
          end
        end else if (run) begin
          cal_d   = 1'b0;
          acc_d   = '0;
          k_d     = '0;
          err_d   = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
`ifdef PAPER_TIMEOUT_EN
        wd_d    = 28'd1;
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (meas_done) begin
          acc_d   = acc_q + ACC_W'(meas_count);
          k_d     = k_q + 1'b1;
          state_d = (k_d == K_NUM) ? ST_AVG : ST_START;
        end
`ifdef PAPER_TIMEOUT_EN
        else if (wd_q >= TIMEOUT - 28'd1) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wd_d = wd_q + 28'd1;
        end
`endif
      end
      ST_AVG: begin
        avg_d   = acc_q[ACC_W-1:AVG_LOG2];
        sidx_d  = '0;
        found_d = 1'b0;
        state_d = cal_q ? ST_STORE : ST_SCAN;
      end
      ST_STORE: begin
        tbl_we  = 1'b1;
        state_d = ST_DONE;
      end
      ST_SCAN: begin
        if (take) begin
          best_d  = sidx_q;
          bdiff_d = diff;
          found_d = 1'b1;
        end
        if (sidx_q == MAX_IDX) begin
          state_d = ST_DONE;
          if (found_d) begin
            number_d = {4'd0, best_d};
            nvalid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          sidx_d = sidx_q + 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_6M or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cal_q    <= 1'b0;
      idx_q    <= '0;
      acc_q    <= '0;
      k_q      <= '0;
      avg_q    <= '0;
      sidx_q   <= '0;
      best_q   <= '0;
      bdiff_q  <= '0;
      found_q  <= 1'b0;
      number_q <= '0;
      nvalid_q <= 1'b0;
      err_q    <= 1'b0;
`ifdef PAPER_TIMEOUT_EN
      wd_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cal_q    <= cal_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      avg_q    <= avg_d;
      sidx_q   <= sidx_d;
      best_q   <= best_d;
      bdiff_q  <= bdiff_d;
      found_q  <= found_d;
      number_q <= number_d;
      nvalid_q <= nvalid_d;
      err_q    <= err_d;
`ifdef PAPER_TIMEOUT_EN
      wd_q     <= wd_d;
`endif
    end
  end

  assign meas_start   = (state_q == ST_START);
  assign busy         = (state_q != ST_IDLE);
  assign number       = number_q;
  assign number_valid = nvalid_q;
  assign err          = err_q;

endmodule

// File: tb/tb_paper_meas_ctrl.sv
// tb_paper_meas_ctrl: directed vectors, corner sequences and random
// operations checked against a behavioural model of the meter.
`timescale 1ns/1ps
module tb_paper_meas_ctrl;

  localparam int CW = 28;
  localparam int NV = 12;
`ifdef PAPER_TIMEOUT_EN
  localparam logic [27:0] TO_P = 28'd100;
`else
  localparam logic [27:0] TO_P = paper_pkg::DEF_TIMEOUT;
`endif

  logic          clk_6M = 1'b0;
  logic          reset_n = 1'b0;
  logic          run = 1'b0;
  logic          cal_req = 1'b0;
  logic [3:0]    cal_idx = '0;
  logic          meas_done = 1'b0;
  logic [CW-1:0] meas_count = '0;
  logic          meas_start, number_valid, busy, err;
  logic [7:0]    number;
  logic [10:0]   ref_valid;

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] m_tbl [11];
  bit            m_ok [11];
  logic [7:0]    m_num = '0;
  bit            m_err = 1'b0;

  typedef struct {
    bit                  cal;
    logic [3:0]          idx;
    bit                  both;
    bit                  stray;
    logic [3:0][CW-1:0]  c;
    logic [7:0]          num;
    bit                  e;
    bit                  nv;
    logic [10:0]         mask;
  } vec_t;

  vec_t vt [NV];

  always #83 clk_6M = ~clk_6M;

  paper_meas_ctrl #(.TIMEOUT(TO_P)) dut (
    .clk_6M       (clk_6M),
    .reset_n      (reset_n),
    .run          (run),
    .cal_req      (cal_req),
    .cal_idx      (cal_idx),
    .meas_start   (meas_start),
    .meas_done    (meas_done),
    .meas_count   (meas_count),
    .number       (number),
    .number_valid (number_valid),
    .busy         (busy),
    .ref_valid    (ref_valid),
    .err          (err)
  );

  initial begin
    #(166 * 30000);
    $display("FAIL watchdog: got no finish, required finish within 30000 cycles");
    $fatal(1);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [10:0] m_mask();
    logic [10:0] m;
    m = '0;
    for (int i = 0; i <= 10; i++) m[i] = m_ok[i];
    return m;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i <= 10; i++) begin
      m_ok[i] = 1'b0;
      m_tbl[i] = '0;
    end
    m_num = '0;
    m_err = 1'b0;
  endfunction

  function automatic vec_t mk(bit cal, logic [3:0] idx, bit both, bit stray,
                              int c0, int c1, int c2, int c3,
                              logic [7:0] num, bit e, bit nv, logic [10:0] mask);
    vec_t v;
    v.cal = cal; v.idx = idx; v.both = both; v.stray = stray;
    v.c = {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
    v.num = num; v.e = e; v.nv = nv; v.mask = mask;
    return v;
  endfunction

  task automatic start_req(input bit cal, input logic [3:0] idx,
                           input bit both, input bit stray);
    if (stray) begin
      @(negedge clk_6M);
      meas_done = 1'b1;
      meas_count = '1;
      @(negedge clk_6M);
      meas_done = 1'b0;
    end
    @(negedge clk_6M);
    cal_req = cal;
    cal_idx = idx;
    run = !cal || both;
    @(negedge clk_6M);
    cal_req = 1'b0;
    run = 1'b0;
  endtask

  task automatic feed(input logic [3:0][CW-1:0] c, input bit stray, output bit ok);
    ok = 1'b1;
    for (int w = 0; w < 4; w++) begin
      int t = 0;
      while (!meas_start && t < 10) begin
        @(negedge clk_6M);
        t++;
      end
      chk("start_latency", t, 0);
      if (!meas_start) begin
        ok = 1'b0;
        return;
      end
      if (stray && w == 0) begin
        meas_done = 1'b1;
        meas_count = '1;
      end
      @(negedge clk_6M);
      meas_done = 1'b0;
      chk("start_width", meas_start, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk_6M);
      meas_done = 1'b1;
      meas_count = c[w];
      @(negedge clk_6M);
      meas_done = 1'b0;
    end
  endtask

  task automatic finish_watch(input logic [3:0] idx, output int nv_cnt,
                              output int nv_lat, output int rv_lat, output int bz_lat);
    nv_cnt = 0; nv_lat = -1; rv_lat = -1; bz_lat = -1;
    for (int j = 1; j <= 20; j++) begin
      if (j > 1) @(negedge clk_6M);
      if (number_valid) begin
        nv_cnt++;
        if (nv_lat < 0) nv_lat = j;
      end
      if (idx <= 4'd10 && ref_valid[idx] && rv_lat < 0) rv_lat = j;
      if (!busy && bz_lat < 0) bz_lat = j;
    end
  endtask

  task automatic do_op(input bit cal, input logic [3:0] idx, input bit both,
                       input bit stray, input logic [3:0][CW-1:0] c, output int nv_cnt);
    longint sum, d, bd;
    logic [CW-1:0] avg;
    int best, nv_lat, rv_lat, bz_lat;
    bit fresh, ok;
    sum = 0;
    for (int w = 0; w < 4; w++) sum += longint'(c[w]);
    avg = CW'(sum / 4);
    fresh = !m_ok[idx];
    nv_cnt = 0;
    start_req(cal, idx, both, stray);
    feed(c, stray, ok);
    if (!ok) return;
    finish_watch(idx, nv_cnt, nv_lat, rv_lat, bz_lat);
    best = -1;
    bd = 0;
    if (cal) begin
      m_tbl[idx] = avg;
      m_ok[idx] = 1'b1;
      m_err = 1'b0;
    end else begin
      for (int i = 0; i <= 10; i++) begin
        if (m_ok[i]) begin
          d = longint'(avg) - longint'(m_tbl[i]);
          if (d < 0) d = -d;
          if (best < 0 || d < bd) begin
            best = i;
            bd = d;
          end
        end
      end
      if (best < 0) m_err = 1'b1;
      else begin
        m_err = 1'b0;
        m_num = 8'(best);
      end
    end
    chk("number", number, m_num);
    chk("err", err, m_err);
    chk("nv_count", nv_cnt, (!cal && best >= 0) ? 1 : 0);
    if (!cal && best >= 0) chk("nv_latency", nv_lat, 13);
    if (cal && fresh) chk("ref_latency", rv_lat, 3);
    chk("busy_fall", bz_lat, cal ? 4 : 14);
    chk("ref_valid", ref_valid, m_mask());
  endtask

  task automatic bad_idx(input logic [3:0] idx);
    int starts = 0;
    @(negedge clk_6M);
    cal_req = 1'b1;
    cal_idx = idx;
    @(negedge clk_6M);
    cal_req = 1'b0;
    chk("bad_err", err, 1);
    for (int j = 0; j < 5; j++) begin
      if (meas_start || busy) starts++;
      @(negedge clk_6M);
    end
    chk("bad_no_start", starts, 0);
    m_err = 1'b1;
  endtask

  initial begin
    int nvc;
    bit ok;
    logic [3:0][CW-1:0] rc;
    m_clear();
    vt[0]  = mk(1'b0, 4'd0, 1'b0, 1'b0, 500, 500, 500, 500, 8'd0, 1'b1, 1'b0, 11'h000);
    vt[1]  = mk(1'b1, 4'd1, 1'b0, 1'b0, 70000, 70000, 70000, 70000, 8'd0, 1'b0, 1'b0, 11'h002);
    vt[2]  = mk(1'b1, 4'd2, 1'b0, 1'b0, 95000, 95000, 95000, 95000, 8'd0, 1'b0, 1'b0, 11'h006);
    vt[3]  = mk(1'b0, 4'd0, 1'b0, 1'b0, 93000, 94000, 96000, 97000, 8'd2, 1'b0, 1'b1, 11'h006);
    vt[4]  = mk(1'b1, 4'd0, 1'b0, 1'b0, 40000, 40000, 40000, 40000, 8'd2, 1'b0, 1'b0, 11'h007);
    vt[5]  = mk(1'b1, 4'd1, 1'b0, 1'b0, 60000, 60000, 60000, 60000, 8'd2, 1'b0, 1'b0, 11'h007);
    vt[6]  = mk(1'b0, 4'd0, 1'b0, 1'b0, 50000, 50000, 50000, 50000, 8'd0, 1'b0, 1'b1, 11'h007);
    vt[7]  = mk(1'b1, 4'd3, 1'b0, 1'b1, 1, 2, 2, 2, 8'd0, 1'b0, 1'b0, 11'h00F);
    vt[8]  = mk(1'b1, 4'd4, 1'b0, 1'b0, 2, 2, 2, 2, 8'd0, 1'b0, 1'b0, 11'h01F);
    vt[9]  = mk(1'b0, 4'd0, 1'b0, 1'b0, 2, 2, 2, 2, 8'd4, 1'b0, 1'b1, 11'h01F);
    vt[10] = mk(1'b1, 4'd5, 1'b1, 1'b0, 3000, 3000, 3000, 3000, 8'd4, 1'b0, 1'b0, 11'h03F);
    vt[11] = mk(1'b0, 4'd0, 1'b0, 1'b0, 3000, 3000, 3000, 3004, 8'd5, 1'b0, 1'b1, 11'h03F);

    repeat (3) @(negedge clk_6M);
    chk("rst_number", number, 0);
    chk("rst_nv", number_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ref_valid", ref_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_meas_start", meas_start, 0);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      do_op(vt[i].cal, vt[i].idx, vt[i].both, vt[i].stray, vt[i].c, nvc);
      chk($sformatf("vec%0d_number", i), number, vt[i].num);
      chk($sformatf("vec%0d_err", i), err, vt[i].e);
      chk($sformatf("vec%0d_nv", i), nvc, vt[i].nv);
      chk($sformatf("vec%0d_mask", i), ref_valid, vt[i].mask);
    end

    bad_idx(4'd11);
    chk("bad_mask", ref_valid, 11'h03F);

    start_req(1'b0, 4'd0, 1'b0, 1'b0);
    feed({4{28'd3000}}, 1'b0, ok);
    repeat (4) @(negedge clk_6M);
    chk("scan_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("scanrst_number", number, 0);
    chk("scanrst_nv", number_valid, 0);
    chk("scanrst_busy", busy, 0);
    chk("scanrst_ref_valid", ref_valid, 0);
    chk("scanrst_err", err, 0);
    chk("scanrst_meas_start", meas_start, 0);
    @(negedge clk_6M);
    reset_n = 1'b1;
    m_clear();

    for (int n = 0; n < 40; n++) begin
      int r = $urandom_range(0, 9);
      int mode = $urandom_range(0, 2);
      for (int w = 0; w < 4; w++) begin
        if (mode == 0) rc[w] = CW'($urandom_range(0, 4000));
        else if (mode == 1) rc[w] = CW'($urandom);
        else rc[w] = '1;
      end
      if (r == 0) bad_idx(4'($urandom_range(11, 15)));
      else if (r < 5)
        do_op(1'b1, 4'($urandom_range(0, 10)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), rc, nvc);
      else
        do_op(1'b0, 4'd0, 1'b0, 1'($urandom_range(0, 1)), rc, nvc);
    end

`ifdef PAPER_TIMEOUT_EN
    begin
      logic [10:0] msk;
      int t = 0;
      int nvs = 0;
      msk = ref_valid;
      start_req(1'b0, 4'd0, 1'b0, 1'b0);
      chk("to_start", meas_start, 1);
      while (!err && t < 150) begin
        @(negedge clk_6M);
        if (number_valid) nvs++;
        t++;
      end
      chk("to_latency", t, 100);
      chk("to_busy", busy, 0);
      chk("to_nv", nvs, 0);
      chk("to_mask", ref_valid, msk);
      m_err = 1'b1;
    end
`endif

    repeat (2) @(negedge clk_6M);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
